// File: rtl/md_ctrl.sv
// Multiply/divide controller owning HI/LO: multi-cycle mult/div sequencing plus single-cycle mthi/mtlo.
// Latency: mult MULT_CYCLES, div DIV_CYCLES edges after issue; mthi/mtlo visible after one edge.
// Backpressure: combinational stall holds any D-stage HI/LO user while busy or while a mult/div issues.
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  e_md_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] cnt;
    logic [31:0]   res_hi, res_lo;
    logic          res_we;
    logic          is_md, is_mul, sgn_div, last;
    logic [63:0]   prod_s, prod_u;
    logic [31:0]   abs_a, abs_b, divisor, uq, ur, sq, sr;
    logic [31:0]   nxt_hi, nxt_lo;

    assign is_md  = (e_md_op >= 3'd1) && (e_md_op <= 3'd4);
    assign is_mul = (e_md_op == 3'd1) || (e_md_op == 3'd2);
    assign last   = (state == BUSY) && (cnt == CW'(1));

    // Signed divide runs on magnitudes so INT_MIN / -1 wraps to INT_MIN with zero remainder.
    always_comb begin
        prod_s  = {{32{e_rs[31]}}, e_rs} * {{32{e_rt[31]}}, e_rt};
        prod_u  = {32'd0, e_rs} * {32'd0, e_rt};
        sgn_div = (e_md_op == 3'd3);
        abs_a   = (sgn_div && e_rs[31]) ? -e_rs : e_rs;
        abs_b   = (sgn_div && e_rt[31]) ? -e_rt : e_rt;
        divisor = (abs_b == 32'd0) ? 32'd1 : abs_b;
        uq      = abs_a / divisor;
        ur      = abs_a % divisor;
        sq      = (sgn_div && (e_rs[31] ^ e_rt[31])) ? -uq : uq;
        sr      = (sgn_div && e_rs[31]) ? -ur : ur;
        nxt_hi  = sr;
        nxt_lo  = sq;
        if (e_md_op == 3'd1) begin
            nxt_hi = prod_s[63:32];
            nxt_lo = prod_s[31:0];
        end else if (e_md_op == 3'd2) begin
            nxt_hi = prod_u[63:32];
            nxt_lo = prod_u[31:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (is_md) state_nxt = BUSY;
            BUSY:    if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == BUSY);
        stall = d_md_use & (busy | is_md);
    end

    // Ops arriving while BUSY are dropped; divide by zero clears res_we so HI/LO survive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            res_hi <= '0;
            res_lo <= '0;
            res_we <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (state == IDLE) begin
            if (is_md) begin
                cnt    <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                res_hi <= nxt_hi;
                res_lo <= nxt_lo;
                res_we <= is_mul || (e_rt != 32'd0);
            end else if (e_md_op == 3'd5) begin
                hi <= e_rs;
            end else if (e_md_op == 3'd6) begin
                lo <= e_rs;
            end
        end else begin
            cnt <= cnt - CW'(1);
            if (last && res_we) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end
endmodule

// File: tb/tb_md_ctrl.sv
// Bench for md_ctrl: directed and random ops; completions checked by a scoreboard monitor
// against a 64-bit integer arithmetic model of HI/LO.
module tb_md_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  e_md_op = 3'd0;
    logic [31:0] e_rs = 32'd0;
    logic [31:0] e_rt = 32'd0;
    logic        d_md_use = 1'b0;
    logic        busy, stall;
    logic [31:0] hi, lo;

    int          total = 0;
    int          bad = 0;
    int          illegal_seen = 0;
    int          illegal_exp = 0;
    bit          mon_abort = 1'b0;
    logic        prev_busy = 1'b0;
    logic [63:0] exp_q[$];
    logic [31:0] ref_hi = 32'd0;
    logic [31:0] ref_lo = 32'd0;

    md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .e_md_op(e_md_op), .e_rs(e_rs), .e_rt(e_rt),
        .d_md_use(d_md_use), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural result of an op given the current HI/LO.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] h,
                                          input logic [31:0] l);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, t, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        t  = {h, l};
        case (op)
            3'd1: t = sa * sb;
            3'd2: t = ua * ub;
            3'd3: if (b != 32'd0) begin
                sq = sa / sb;
                sr = sa % sb;
                q  = sq;
                r  = sr;
                t  = {r[31:0], q[31:0]};
            end
            3'd4: if (b != 32'd0) begin
                q = ua / ub;
                r = ua % ub;
                t = {r[31:0], q[31:0]};
            end
            default: t = {h, l};
        endcase
        return t;
    endfunction

    // Scoreboard monitor: a busy falling edge is a completion and pops the oldest expectation.
    always @(negedge clk) begin
        logic [63:0] e;
        if (prev_busy && !busy) begin
            if (mon_abort) begin
                mon_abort = 1'b0;
            end else if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done_unexpected: got completion expected none at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("done_hi", hi, e[63:32]);
                chk("done_lo", lo, e[31:0]);
            end
        end
        if (busy && e_md_op >= 3'd1 && e_md_op <= 3'd6) illegal_seen++;
        prev_busy = busy;
    end

    task automatic do_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic dmu, input int bad_at);
        logic [63:0] r;
        logic [31:0] oh, ol;
        int          n;
        oh = ref_hi;
        ol = ref_lo;
        r  = model(op, a, b, ref_hi, ref_lo);
        ref_hi = r[63:32];
        ref_lo = r[31:0];
        n = (op <= 3'd2) ? MC : DC;
        exp_q.push_back(r);
        e_md_op = op; e_rs = a; e_rt = b; d_md_use = dmu;
        @(negedge clk);
        chk("issue_stall", stall, dmu);
        chk("issue_busy", busy, 0);
        step();
        e_md_op = 3'd0;
        for (int k = 0; k < n; k++) begin
            if (k == bad_at) begin
                e_md_op = 3'd5;
                e_rs = 32'hDEADBEEF;
                illegal_exp++;
            end
            @(negedge clk);
            chk("run_busy", busy, 1);
            chk("run_stall", stall, dmu);
            chk("run_hi_hold", hi, oh);
            chk("run_lo_hold", lo, ol);
            step();
            e_md_op = 3'd0;
        end
        @(negedge clk);
        chk("end_busy", busy, 0);
        chk("end_stall", stall, 0);
        d_md_use = 1'b0;
        step();
    endtask

    task automatic do_wr(input logic [2:0] op, input logic [31:0] v, input logic dmu);
        if (op == 3'd5) ref_hi = v;
        else            ref_lo = v;
        e_md_op = op; e_rs = v; d_md_use = dmu;
        @(negedge clk);
        chk("wr_stall", stall, 0);
        step();
        e_md_op = 3'd0;
        d_md_use = 1'b0;
        @(negedge clk);
        chk("wr_hi", hi, ref_hi);
        chk("wr_lo", lo, ref_lo);
        chk("wr_busy", busy, 0);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        dmu;

        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        d_md_use = 1'b1;
        #1;
        chk("rst_stall_idle", stall, 0);
        e_md_op = 3'd1;
        #1;
        chk("rst_stall_issue", stall, 1);
        e_md_op = 3'd0;
        d_md_use = 1'b0;
        step();
        reset = 1'b0;
        step();

        do_md(3'd1, 32'hFFFFFFFD, 32'd5, 1'b0, -1);
        do_md(3'd4, 32'd100, 32'd7, 1'b0, -1);
        do_md(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, -1);
        do_md(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, -1);
        do_wr(3'd5, 32'h1234, 1'b1);
        do_wr(3'd6, 32'h5678, 1'b0);
        do_md(3'd3, 32'd55, 32'd0, 1'b0, -1);
        do_md(3'd2, 32'hFFFFFFFF, 32'd2, 1'b1, -1);
        do_md(3'd2, 32'hFFFFFFFF, 32'd3, 1'b0, -1);

        // Reset lands mid-cycle three cycles into a divide.
        e_md_op = 3'd3; e_rs = 32'd1000; e_rt = 32'd3;
        step();
        e_md_op = 3'd0;
        step(); step();
        #2;
        mon_abort = 1'b1;
        reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        ref_hi = 32'd0;
        ref_lo = 32'd0;
        step();
        reset = 1'b0;
        step();
        do_md(3'd1, 32'd6, 32'd7, 1'b0, -1);

        do_md(3'd1, 32'd3, 32'd4, 1'b1, 2);
        do_wr(3'd5, 32'hDEADBEEF, 1'b0);

        for (int i = 0; i < 30; i++) begin
            op  = 3'($urandom_range(1, 6));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            dmu = 1'($urandom_range(0, 1));
            if (op >= 3'd5) do_wr(op, a, dmu);
            else            do_md(op, a, b, dmu, -1);
        end

        chk("illegal_detect", illegal_seen, illegal_exp);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multiply/divide controller for the five-stage pipelined MIPS core. It sits beside the E-stage ALU and owns the HI/LO registers. It sequences multi-cycle mult/multu/div/divu operations with a busy counter and handles single-cycle mthi/mtlo writes. It also generates the stall request that holds a D-stage mult/div/mfhi/mflo/mthi/mtlo instruction while the unit is occupied.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- e_md_op  in  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- e_rs  in  32  forwarded rs value (operand A / mthi/mtlo source)
- e_rt  in  32  forwarded rt value (operand B)
- d_md_use  in  1  D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  out  1  operation in progress
- stall  out  1  combinational stall request to the hazard unit
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- State: IDLE / BUSY, a down-counter `cnt` (width fits max(MULT_CYCLES, DIV_CYCLES)), and latched result registers res_hi and res_lo.
- IDLE, e_md_op ∈ {1..4} at an edge:
  - Compute the result from e_rs/e_rt in that cycle and latch it into res_hi/res_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES and go to BUSY.
- BUSY: cnt decrements each edge. On the edge where cnt goes 1→0, copy res_hi/res_lo into hi/lo and return to IDLE.
- mult: signed 32×32→64; {hi,lo} = product. multu: unsigned equivalent.
- div: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- divu: unsigned quotient/remainder.
- Divide by zero (div/divu, e_rt=0): still occupies DIV_CYCLES; hi/lo unchanged at completion.
- mthi/mtlo in IDLE: hi (resp. lo) ← e_rs at the edge; no busy cycle.
- Any op presented while BUSY is ignored. The stall logic guarantees this never happens; the bench asserts on it.
- stall = d_md_use & (busy | e_md_op ∈ {1..4}).
  - This covers the issue cycle, so a following mfhi/mflo cannot slip past.
  - mthi/mtlo in E does not stall.
- Outputs hi/lo are registers; mfhi/mflo read them directly once unstalled.

## Timing
- Reset (async, any time, including mid-operation): busy=0, cnt=0, hi=0, lo=0, res_hi=res_lo=0, state IDLE; an in-flight result is discarded. stall then depends only on the inputs.
- mult issued with e_md_op=1 sampled at edge T: busy=1 after T; hi/lo updated and busy=0 after edge T+MULT_CYCLES. busy is high for exactly MULT_CYCLES cycles.
- div issued at T completes at edge T+DIV_CYCLES.
- A new mult/div may be accepted at the completion edge itself only if busy was already 0 when sampled; back-to-back ops therefore have ≥1 IDLE cycle between them.
- mthi/mtlo: result is visible after the sampling edge (latency 1).
- stall is purely combinational from the current-cycle busy, e_md_op and d_md_use; there is no registered delay.
- hi/lo never change except at a completion edge, an mthi/mtlo edge, or reset.

## Test plan
- mult e_rs=0xFFFFFFFD (-3), e_rt=5 at edge T → busy high for 5 cycles; after T+5 hi=0xFFFFFFFF, lo=0xFFFFFFF1; hi/lo unchanged at T+1..T+4.
- divu 100/7 → after 10 cycles lo=14, hi=2. Then div 0xFFFFFFF9 (-7)/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero after mthi 0x1234 / mtlo 0x5678 → busy for 10 cycles; hi=0x1234, lo=0x5678 remain.
- Stall: multu 0xFFFFFFFF×2 issued with d_md_use=1 → stall=1 in the issue cycle and all 5 busy cycles, 0 after; hi=1, lo=0xFFFFFFFE. With d_md_use=0, stall stays 0 throughout.
- Reset asserted asynchronously (mid-cycle) 3 cycles into a div → busy, hi, lo read 0 immediately. After release, a new mult 6×7 completes normally with lo=42, hi=0.
- mthi 0xDEADBEEF while busy=1 (illegal) → hi unaffected and the bench assertion fires. The same mthi in IDLE sets hi=0xDEADBEEF one edge later.
